// File: rtl/exc_pkg.sv
// ============================================================================
// exc_pkg : shared types and constants for the TLB-miss exception controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_SAVE     = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HANDLER  = 3'd4,
        ST_RETURN   = 3'd5
    } exc_state_e;

    localparam logic [1:0]  CAUSE_NONE = 2'b00;
    localparam logic [1:0]  CAUSE_ITLB = 2'b01;
    localparam logic [1:0]  CAUSE_DTLB = 2'b10;

    localparam logic [31:0] HANDLER_VEC_DEFAULT = 32'h0000_2000;

endpackage

`default_nettype wire

// File: rtl/exc_drain_timer.sv
// ============================================================================
// exc_drain_timer : counts DRAIN cycles from 0 and flags the final allowed one
// Revision: 1.0
// ============================================================================
`default_nettype none

module exc_drain_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == limit);

endmodule

`default_nettype wire

// File: rtl/exception_ctrl.sv
// ============================================================================
// exception_ctrl : TLB-miss exception sequencer (drain, save, redirect, return)
// Revision: 1.0
// ============================================================================
`default_nettype none

module exception_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_VEC = HANDLER_VEC_DEFAULT,
    parameter int unsigned DRAIN_MAX   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        itlb_miss,
    input  logic [31:0] itlb_pc,
    input  logic        dtlb_miss,
    input  logic [31:0] dtlb_pc,
    input  logic [31:0] dtlb_addr,
    input  logic        iret_req,
    input  logic        pipe_empty,
    input  logic [31:0] sys_epc,
    output logic        flush,
    output logic        stall_fetch,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        sys_tlb_miss,
    output logic [31:0] sys_pc,
    output logic [31:0] sys_addr,
    output logic        sys_iret,
    output logic        supervisor_mode,
    output logic [1:0]  exc_cause,
    output logic        double_fault
);

    localparam logic [7:0] DRAIN_LIMIT = 8'(DRAIN_MAX - 1);

    exc_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  cause_q, cause_d;
    logic        df_q, df_d;
    logic        first_q;
    logic        drain_expired;
    logic        any_miss;

    exc_drain_timer u_drain_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != ST_DRAIN),
        .enable  (state_q == ST_DRAIN),
        .limit   (DRAIN_LIMIT),
        .expired (drain_expired)
    );

    assign any_miss = itlb_miss | dtlb_miss;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        addr_d          = addr_q;
        cause_d         = cause_q;
        df_d            = df_q;
        flush           = 1'b0;
        stall_fetch     = 1'b0;
        pc_redirect     = 1'b0;
        pc_target       = 32'd0;
        sys_tlb_miss    = 1'b0;
        sys_pc          = 32'd0;
        sys_addr        = 32'd0;
        sys_iret        = 1'b0;
        supervisor_mode = 1'b0;
        exc_cause       = cause_q;
        double_fault    = df_q;

        case (state_q)
            ST_IDLE: begin
                exc_cause = CAUSE_NONE;
                if (dtlb_miss) begin
                    pc_d    = dtlb_pc;
                    addr_d  = dtlb_addr;
                    cause_d = CAUSE_DTLB;
                    state_d = ST_DRAIN;
                end else if (itlb_miss) begin
                    pc_d    = itlb_pc;
                    addr_d  = itlb_pc;
                    cause_d = CAUSE_ITLB;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                flush       = first_q;
                stall_fetch = 1'b1;
                if (pipe_empty || drain_expired) begin
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                stall_fetch     = 1'b1;
                sys_tlb_miss    = 1'b1;
                sys_pc          = pc_q;
                sys_addr        = addr_q;
                supervisor_mode = 1'b1;
                state_d         = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                stall_fetch     = 1'b1;
                pc_redirect     = 1'b1;
                pc_target       = HANDLER_VEC;
                supervisor_mode = 1'b1;
                state_d         = ST_HANDLER;
            end
            ST_HANDLER: begin
                supervisor_mode = 1'b1;
                // IRET wins over a coincident miss, which is then dropped silently
                if (iret_req) begin
                    state_d = ST_RETURN;
                end else if (any_miss) begin
                    df_d = 1'b1;
                end
            end
            ST_RETURN: begin
                flush           = 1'b1;
                sys_iret        = 1'b1;
                pc_redirect     = 1'b1;
                pc_target       = sys_epc;
                supervisor_mode = 1'b1;
                state_d         = ST_IDLE;
            end
            default: begin
                exc_cause = CAUSE_NONE;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= 32'd0;
            addr_q  <= 32'd0;
            cause_q <= CAUSE_NONE;
            df_q    <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            cause_q <= cause_d;
            df_q    <= df_d;
            first_q <= (state_q != ST_DRAIN) && (state_d == ST_DRAIN);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exception_ctrl.sv
// ============================================================================
// tb_exception_ctrl : vector table plus reset corner cases for exception_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exception_ctrl;

    typedef enum int {P_IDLE, P_DRAIN1, P_DRAINN, P_SAVE, P_REDIR, P_HAND, P_RET} phase_e;

    typedef struct packed {
        logic        flush;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        stm;
        logic [31:0] spc;
        logic [31:0] saddr;
        logic        siret;
        logic        sup;
        logic [1:0]  cause;
        logic        df;
    } exp_t;

    typedef struct {
        logic        itlb;
        logic [31:0] ipc;
        logic        dtlb;
        logic [31:0] dpc;
        logic [31:0] daddr;
        logic        iret;
        logic        pe;
        exp_t        exp;
    } vec_t;

    localparam logic [31:0] EPC = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        itlb_miss = 1'b0;
    logic [31:0] itlb_pc = 32'd0;
    logic        dtlb_miss = 1'b0;
    logic [31:0] dtlb_pc = 32'd0;
    logic [31:0] dtlb_addr = 32'd0;
    logic        iret_req = 1'b0;
    logic        pipe_empty = 1'b0;
    logic [31:0] sys_epc = EPC;
    logic        flush, stall_fetch, pc_redirect, sys_tlb_miss, sys_iret;
    logic        supervisor_mode, double_fault;
    logic [31:0] pc_target, sys_pc, sys_addr;
    logic [1:0]  exc_cause;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t tbl[$];

    exception_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .itlb_miss       (itlb_miss),
        .itlb_pc         (itlb_pc),
        .dtlb_miss       (dtlb_miss),
        .dtlb_pc         (dtlb_pc),
        .dtlb_addr       (dtlb_addr),
        .iret_req        (iret_req),
        .pipe_empty      (pipe_empty),
        .sys_epc         (sys_epc),
        .flush           (flush),
        .stall_fetch     (stall_fetch),
        .pc_redirect     (pc_redirect),
        .pc_target       (pc_target),
        .sys_tlb_miss    (sys_tlb_miss),
        .sys_pc          (sys_pc),
        .sys_addr        (sys_addr),
        .sys_iret        (sys_iret),
        .supervisor_mode (supervisor_mode),
        .exc_cause       (exc_cause),
        .double_fault    (double_fault)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(phase_e ph, logic [1:0] cause, logic df,
                                logic [31:0] spc, logic [31:0] saddr);
        exp_t e;
        e        = '0;
        e.flush  = (ph == P_DRAIN1) || (ph == P_RET);
        e.stall  = (ph == P_DRAIN1) || (ph == P_DRAINN) || (ph == P_SAVE) || (ph == P_REDIR);
        e.redir  = (ph == P_REDIR) || (ph == P_RET);
        e.target = (ph == P_REDIR) ? 32'h0000_2000 : ((ph == P_RET) ? EPC : 32'd0);
        e.stm    = (ph == P_SAVE);
        e.spc    = (ph == P_SAVE) ? spc : 32'd0;
        e.saddr  = (ph == P_SAVE) ? saddr : 32'd0;
        e.siret  = (ph == P_RET);
        e.sup    = (ph == P_SAVE) || (ph == P_REDIR) || (ph == P_HAND) || (ph == P_RET);
        e.cause  = (ph == P_IDLE) ? 2'b00 : cause;
        e.df     = df;
        return e;
    endfunction

    function automatic vec_t row(logic it, logic [31:0] ipc, logic dt, logic [31:0] dpc,
                                 logic [31:0] dad, logic ir, logic pe, phase_e ph,
                                 logic [1:0] cause, logic df, logic [31:0] spc,
                                 logic [31:0] saddr);
        vec_t v;
        v.itlb  = it;
        v.ipc   = ipc;
        v.dtlb  = dt;
        v.dpc   = dpc;
        v.daddr = dad;
        v.iret  = ir;
        v.pe    = pe;
        v.exp   = mk(ph, cause, df, spc, saddr);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        itlb_miss  = v.itlb;
        itlb_pc    = v.ipc;
        dtlb_miss  = v.dtlb;
        dtlb_pc    = v.dpc;
        dtlb_addr  = v.daddr;
        iret_req   = v.iret;
        pipe_empty = v.pe;
        sb_q.push_back(v.exp);
    endtask

    task automatic check(input string name);
        exp_t act, exp;
        act = {flush, stall_fetch, pc_redirect, pc_target, sys_tlb_miss, sys_pc,
               sys_addr, sys_iret, supervisor_mode, exc_cause, double_fault};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, actual=%h", name, act);
        end else begin
            exp = sb_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: actual flush=%b stall=%b redir=%b tgt=%h stm=%b spc=%h sad=%h iret=%b sup=%b cause=%b df=%b | required flush=%b stall=%b redir=%b tgt=%h stm=%b spc=%h sad=%h iret=%b sup=%b cause=%b df=%b",
                         name, act.flush, act.stall, act.redir, act.target, act.stm, act.spc,
                         act.saddr, act.siret, act.sup, act.cause, act.df,
                         exp.flush, exp.stall, exp.redir, exp.target, exp.stm, exp.spc,
                         exp.saddr, exp.siret, exp.sup, exp.cause, exp.df);
            end
        end
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = row(0, 0, 0, 0, 0, 0, 0, P_IDLE, 2'b00, 0, 0, 0);
        itlb_miss = v.itlb; dtlb_miss = v.dtlb; iret_req = v.iret; pipe_empty = v.pe;
    endtask

    initial begin
        // Seq A: DTLB miss, min latency, ignored miss in SAVE, miss+iret in HANDLER
        tbl.push_back(row(0, 0, 1, 32'h100, 32'hDEAD0000, 0, 1, P_DRAIN1, 2'b10, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_SAVE,   2'b10, 0, 32'h100, 32'hDEAD0000));
        tbl.push_back(row(1, 32'h999, 0, 0, 0, 0, 1, P_REDIR, 2'b10, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_HAND,   2'b10, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_HAND,   2'b10, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 32'h77, 32'h88, 1, 1, P_RET, 2'b10, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_IDLE,   2'b00, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, P_IDLE,   2'b00, 0, 0, 0));
        // Seq B: simultaneous misses, full drain timeout, double fault
        tbl.push_back(row(1, 32'h300, 1, 32'h400, 32'hBEEF0004, 0, 0, P_DRAIN1, 2'b10, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(row(i == 3, 32'h5A5, 0, 0, 0, 0, 0, P_DRAINN, 2'b10, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, P_SAVE,   2'b10, 0, 32'h400, 32'hBEEF0004));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, P_REDIR,  2'b10, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, P_HAND,   2'b10, 0, 0, 0));
        tbl.push_back(row(1, 32'h600, 0, 0, 0, 0, 1, P_HAND, 2'b10, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_HAND,   2'b10, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, P_RET,    2'b10, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_IDLE,   2'b00, 1, 0, 0));
        // Seq C: ITLB-only miss saves itlb_pc as both PC and address
        tbl.push_back(row(1, 32'h500, 0, 0, 0, 0, 0, P_DRAIN1, 2'b01, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_SAVE,   2'b01, 1, 32'h500, 32'h500));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_REDIR,  2'b01, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_HAND,   2'b01, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, P_RET,    2'b01, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, P_IDLE,   2'b00, 1, 0, 0));

        #3;
        sb_q.push_back(mk(P_IDLE, 2'b00, 0, 0, 0));
        check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i));
        end

        // Reset asserted while in SAVE must zero outputs without a clock edge
        drive(row(0, 0, 1, 32'hABC, 32'hDEF, 0, 1, P_DRAIN1, 2'b10, 1, 0, 0));
        @(negedge clk);
        check("pre_reset_drain");
        drive(row(0, 0, 0, 0, 0, 0, 1, P_SAVE, 2'b10, 1, 32'hABC, 32'hDEF));
        @(negedge clk);
        check("pre_reset_save");
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.push_back(mk(P_IDLE, 2'b00, 0, 0, 0));
        check("async_reset_in_save");
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        sb_q.push_back(mk(P_IDLE, 2'b00, 0, 0, 0));
        @(negedge clk);
        check("idle_after_release");
        drive(row(0, 0, 1, 32'h10, 32'h20, 0, 1, P_DRAIN1, 2'b10, 0, 0, 0));
        @(negedge clk);
        check("miss_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
